mdu_iter: RTL and testbench
===========================

// Module: mdu_iter
// PURPOSE
//   Iterative multiply/divide unit for the MIPS EX stage. Consumes rs on src_a and the
//   operand-B mux output (sign-extended immediate or rt) on src_b. Computes MULT/MULTU
//   (shift-add) and DIV/DIVU (restoring) over XLEN cycles into the HI/LO registers.
//   Also services MTHI/MTLO writes. The pipeline stalls on busy.
// PARAMETERS
//   XLEN  32  operand width; HI and LO are each XLEN bits; iteration count = XLEN
// PORTS
//   clk      in   1     rising-edge clock
//   rst      in   1     synchronous, active-high reset
//   start    in   1     launch op; sampled only in IDLE
//   op       in   2     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a    in   XLEN  rs (multiplicand / dividend)
//   src_b    in   XLEN  operand-mux output (multiplier / divisor)
//   mthi     in   1     write wdata to HI (IDLE only)
//   mtlo     in   1     write wdata to LO (IDLE only)
//   wdata    in   XLEN  MTHI/MTLO data
//   busy     out  1     operation in flight; pipeline must hold
//   done     out  1     one-cycle pulse: HI/LO just updated by an op
//   hi       out  XLEN  HI register (product[63:32] / remainder)
//   lo       out  XLEN  LO register (product[31:0] / quotient)
// BEHAVIOUR
//   Reset (rst=1 at an edge, any state): state=IDLE; hi=lo=0; busy=0; done=0; all
//     iteration registers cleared. An op in flight is abandoned; no HI/LO write.
//   FSM: IDLE -> RUN -> FIX -> IDLE.
//     IDLE: edge with start=1 latches op and magnitudes |a|, |b| (signed ops; unsigned
//       ops pass through unchanged), result signs, and count=0. Next state is RUN and
//       busy=1 from that edge.
//     RUN: one iteration per edge; count increments; leave RUN after XLEN iterations.
//       MUL: 2*XLEN-bit accumulator with shift-add of the multiplier LSB.
//       DIV: restoring; shift remainder left, trial-subtract divisor, quotient bit = !borrow.
//     FIX: signed MUL negates the 64-bit product if sign(a)^sign(b).
//       Signed DIV negates the quotient if sign(a)^sign(b); the remainder takes sign(a).
//       At this edge: hi/lo written, done=1 for one cycle, busy=0, return to IDLE.
//   Latency: start sampled at edge E0; busy=1 for E0..E(XLEN+1); the hi/lo write and
//     done occur at E(XLEN+1) (E33 for XLEN=32). Results are visible in the cycle after E33.
//   Divide by zero (DIV/DIVU with src_b==0): skip RUN. At E1: lo=all-ones, hi=src_a
//     (raw, unsigned), done=1, busy=0.
//   Overflow 0x80000000 / -1 (DIV): lo=0x80000000, hi=0. This needs no special case.
//   start while busy: ignored, with no queueing. src_a/src_b may change after E0.
//   mthi/mtlo: applied at the edge in IDLE when start=0. Both asserted writes both.
//     Ignored while busy. When asserted with start in IDLE, start wins and the write is dropped.
//   done and busy are never both 1. done never asserts on MTHI/MTLO.
// TESTING
//   1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at start+33; hi=0xFFFFFFFE lo=0x00000001
//   2 MULT a=-3 b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; busy high for exactly 33 cycles
//   3 DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU a=100 b=7 -> lo=14 hi=2
//   4 DIV b=0, a=0x1234 -> done 1 cycle after start; lo=0xFFFFFFFF hi=0x00001234
//   5 rst at RUN count=10 after mthi=0xAA -> next cycle hi=lo=0, busy=0, no done pulse
//   6 start plus mthi in IDLE, start pulsed again mid-RUN -> only first op completes; hi=op result

Source files
------------

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes
module mdu_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            mthi,
   input  logic            mtlo,
   input  logic [XLEN-1:0] wdata,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t            state, state_nx;
   logic              is_div, neg_q, neg_r, raw;
   logic [XLEN-1:0]   opnd;
   logic [2*XLEN-1:0] acc;
   logic [CW-1:0]     count;

   logic              a_neg, b_neg, div_zero;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN:0]     mul_sum, div_shift;
   logic [XLEN+1:0]   div_diff;
   logic              div_fits;
   logic [2*XLEN-1:0] acc_step;
   logic [XLEN-1:0]   fix_hi, fix_lo;

   // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
   always_comb begin
      a_neg     = !op[0] && src_a[XLEN-1];
      b_neg     = !op[0] && src_b[XLEN-1];
      a_mag     = a_neg ? -src_a : src_a;
      b_mag     = b_neg ? -src_b : src_b;
      div_zero  = op[1] && (src_b == '0);

      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
      div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, opnd};
      div_fits  = (div_diff[XLEN+1:XLEN] == 2'b00);

      if (!is_div)
         acc_step = {mul_sum, acc[XLEN-1:1]};
      else if (div_fits)
         acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
         acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
   end

   always_comb begin
      fix_hi = acc[2*XLEN-1:XLEN];
      fix_lo = acc[XLEN-1:0];
      if (raw) begin
         fix_hi = acc[2*XLEN-1:XLEN];
         fix_lo = acc[XLEN-1:0];
      end else if (!is_div) begin
         if (neg_q)
            {fix_hi, fix_lo} = -acc;
      end else begin
         if (neg_r)
            fix_hi = -acc[2*XLEN-1:XLEN];
         if (neg_q)
            fix_lo = -acc[XLEN-1:0];
      end
   end

   always_comb begin
      state_nx = state;
      busy     = (state != S_IDLE);
      case (state)
         S_IDLE:  if (start) state_nx = div_zero ? S_FIX : S_RUN;
         S_RUN:   if (count == CW'(XLEN-1)) state_nx = S_FIX;
         S_FIX:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         raw    <= 1'b0;
         opnd   <= '0;
         acc    <= '0;
         count  <= '0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  is_div <= op[1];
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  raw    <= div_zero;
                  count  <= '0;
                  if (div_zero) begin
                     acc <= {src_a, {XLEN{1'b1}}};
                  end else if (op[1]) begin
                     acc  <= {{XLEN{1'b0}}, a_mag};
                     opnd <= b_mag;
                  end else begin
                     acc  <= {{XLEN{1'b0}}, b_mag};
                     opnd <= a_mag;
                  end
               end else begin
                  if (mthi) hi <= wdata;
                  if (mtlo) lo <= wdata;
               end
            end
            S_RUN: begin
               acc   <= acc_step;
               count <= count + 1'b1;
            end
            S_FIX: begin
               hi   <= fix_hi;
               lo   <= fix_lo;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - bench for mdu_iter: arithmetic reference model, per-cycle compare, directed and random ops
module tb_mdu_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic [31:0] wdata = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_pass = 0;
   int n_total = 0;

   mdu_iter #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // {hi, lo} an op must produce, from plain 64-bit arithmetic
   function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (o)
         2'b00: begin p = sa * sb; return p; end
         2'b01: begin p = ua * ub; return p; end
         default: begin
            if (b == 32'b0) return {a, 32'hFFFF_FFFF};
            if (o == 2'b10) begin q = sa / sb; r = sa % sb; end
            else begin q = longint'(ua / ub); r = longint'(ua % ub); end
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   logic [31:0] m_hi, m_lo;
   logic [63:0] m_res;
   logic        m_done;
   int          m_left;

   always @(posedge clk) begin
      if (rst) begin
         m_hi <= '0; m_lo <= '0; m_left <= 0; m_done <= 1'b0; m_res <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; m_done <= 1'b1;
            end
         end else if (start) begin
            m_res  <= ref_res(op, src_a, src_b);
            m_left <= (op[1] && src_b == 32'b0) ? 1 : 33;
         end else begin
            if (mthi) m_hi <= wdata;
            if (mtlo) m_lo <= wdata;
         end
      end
   end

   always @(negedge clk) begin
      check("cyc_busy", 64'(busy), 64'(m_left != 0));
      check("cyc_done", 64'(done), 64'(m_done));
      check("cyc_hi", 64'(hi), 64'(m_hi));
      check("cyc_lo", 64'(lo), 64'(m_lo));
   end

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(negedge clk);
      start = 1'b0; src_a = $urandom; src_b = $urandom;
      lat = -1; busy_cnt = 0;
      for (int i = 0; i <= 40; i++) begin
         if (i > 0) @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin lat = i; break; end
      end
   endtask

   int lat, bc, pulses;

   initial begin
      check("model_multu", ref_res(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
      check("model_mult", ref_res(2'b00, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
      check("model_div", ref_res(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
      check("model_ovf", ref_res(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

      repeat (2) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);
      rst = 1'b0;

      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
      check("t1_latency", 64'(lat), 64'd33);
      check("t1_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, bc);
      check("t2_busy_cycles", 64'(bc), 64'd33);
      check("t2_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bc);
      check("t3_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(2'b11, 32'd100, 32'd7, lat, bc);
      check("t3_divu", {hi, lo}, 64'h0000_0002_0000_000E);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
      check("t3_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

      run_op(2'b10, 32'h0000_1234, 32'd0, lat, bc);
      check("t4_latency", 64'(lat), 64'd1);
      check("t4_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);

      // reset mid-run after an MTHI
      @(negedge clk);
      mthi = 1'b1; wdata = 32'hAA;
      @(negedge clk);
      mthi = 1'b0;
      check("t5_mthi", 64'(hi), 64'hAA);
      start = 1'b1; op = 2'b01; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_after_rst", {31'b0, busy, hi, lo}, 64'd0);
      pulses = 0;
      repeat (40) begin @(negedge clk); if (done) pulses++; end
      check("t5_no_done", 64'(pulses), 64'd0);

      // start with mthi in IDLE, then a second start mid-run
      start = 1'b1; op = 2'b01; src_a = 32'h0001_0000; src_b = 32'h0003_0000;
      mthi = 1'b1; wdata = 32'h55;
      @(negedge clk);
      start = 1'b0; mthi = 1'b0;
      check("t6_mthi_dropped", 64'(hi), 64'd0);
      repeat (5) @(negedge clk);
      start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      pulses = 0;
      repeat (40) begin @(negedge clk); if (done) pulses++; end
      check("t6_one_done", 64'(pulses), 64'd1);
      check("t6_hilo", {hi, lo}, 64'h0000_0003_0000_0000);

      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         rst   = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 5) == 0);
         op    = 2'($urandom_range(0, 3));
         mthi  = ($urandom_range(0, 5) == 0);
         mtlo  = ($urandom_range(0, 5) == 0);
         wdata = $urandom;
         case ($urandom_range(0, 7))
            0: begin src_a = $urandom; src_b = 32'd0; end
            1: begin src_a = 32'h8000_0000; src_b = 32'hFFFF_FFFF; end
            2: begin src_a = $urandom_range(0, 50); src_b = $urandom_range(0, 9); end
            3: begin src_a = -$urandom_range(0, 50); src_b = -$urandom_range(1, 9); end
            default: begin src_a = $urandom; src_b = $urandom; end
         endcase
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      repeat (40) @(negedge clk);
      check("final_idle", 64'(busy), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
